// File: rtl/register_scoreboard_pkg.sv
// Shared scoreboard types: register IDs, FSM states and writeback port indices.
package register_scoreboard_pkg;

  localparam int SB_NUM_REGS  = 16;
  localparam int SB_REG_W     = $clog2(SB_NUM_REGS);
  localparam int SB_PENDING_W = 3;
  localparam int SB_NUM_WB    = 2;

  typedef logic [SB_REG_W-1:0] RegisterID;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAINING,
    SB_DRAINED
  } scoreboard_state_t;

  typedef enum logic {
    WB_EXEC = 1'b0,
    WB_LOAD = 1'b1
  } wb_port_t;

endpackage

// File: rtl/register_scoreboard_sb_counter.sv
// One register's outstanding-write counter: +1 on issue, -0/1/2 on release,
// clamped at zero with an underflow strobe and saturated at its maximum.
module sb_counter #(
  parameter int PENDING_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic [1:0]           dec,
  output logic [PENDING_W-1:0] cnt,
  output logic                 full,
  output logic                 underflow,
  output logic [1:0]           applied_dec
);

  localparam logic [PENDING_W-1:0] CNT_MAX = '1;

  logic [PENDING_W-1:0] cnt_reg, cnt_next;
  logic [PENDING_W:0]   avail;
  logic [PENDING_W:0]   dec_ext;
  logic [PENDING_W:0]   diff;

  always_comb begin
    avail       = {1'b0, cnt_reg} + {{PENDING_W{1'b0}}, inc};
    dec_ext     = {{(PENDING_W-1){1'b0}}, dec};
    diff        = avail - dec_ext;
    underflow   = 1'b0;
    applied_dec = dec;
    cnt_next    = cnt_reg;
    if (dec_ext > avail) begin
      // Only what was actually outstanding is released; the rest is the error.
      underflow   = 1'b1;
      applied_dec = avail[1:0];
      cnt_next    = '0;
    end else if (diff[PENDING_W]) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = diff[PENDING_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt  = cnt_reg;
  assign full = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: counts in-flight writes per register, gates decode issue
// on RAW hazards and counter saturation, and provides a drain handshake.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int PENDING_W = SB_PENDING_W,
  parameter int REG_W     = $clog2(NUM_REGS),
  parameter int TOTAL_W   = $clog2(NUM_REGS * ((1 << PENDING_W) - 1) + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_W-1:0]     issue_src_a,
  input  logic [REG_W-1:0]     issue_src_b,
  input  logic                 issue_src_a_en,
  input  logic                 issue_src_b_en,
  input  logic [REG_W-1:0]     issue_dst,
  input  logic                 issue_dst_en,
  input  logic [1:0]           wb_valid,
  input  logic [2*REG_W-1:0]   wb_reg,
  input  logic                 drain_req,
  output logic                 drain_ack,
  output logic [NUM_REGS-1:0]  reg_valid,
  output logic [TOTAL_W-1:0]   outstanding_total,
  output logic                 underflow_err
);

  scoreboard_state_t state_reg, state_next;

  logic [PENDING_W-1:0] cnt_arr     [NUM_REGS];
  logic [1:0]           dec_arr     [NUM_REGS];
  logic [1:0]           applied_arr [NUM_REGS];
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  busy_vec;
  logic [NUM_REGS-1:0]  full_vec;
  logic [NUM_REGS-1:0]  uf_vec;

  logic [REG_W-1:0]     wb_reg_exec;
  logic [REG_W-1:0]     wb_reg_load;
  logic                 fire;
  logic                 issue_write;
  logic [TOTAL_W-1:0]   rel_sum;
  logic [TOTAL_W-1:0]   total_reg, total_next;
  logic                 underflow_err_reg;

  assign wb_reg_exec = wb_reg[REG_W-1:0];
  assign wb_reg_load = wb_reg[2*REG_W-1:REG_W];

  assign fire        = issue_valid && issue_ready;
  assign issue_write = fire && issue_dst_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic rel_exec;
      logic rel_load;

      assign rel_exec    = wb_valid[WB_EXEC] && (wb_reg_exec == REG_W'(gi));
      assign rel_load    = wb_valid[WB_LOAD] && (wb_reg_load == REG_W'(gi));
      assign dec_arr[gi] = {1'b0, rel_exec} + {1'b0, rel_load};
      assign inc_vec[gi] = issue_write && (issue_dst == REG_W'(gi));

      sb_counter #(
        .PENDING_W (PENDING_W)
      ) u_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .inc         (inc_vec[gi]),
        .dec         (dec_arr[gi]),
        .cnt         (cnt_arr[gi]),
        .full        (full_vec[gi]),
        .underflow   (uf_vec[gi]),
        .applied_dec (applied_arr[gi])
      );

      assign busy_vec[gi] = |cnt_arr[gi];
    end
  endgenerate

  assign reg_valid = ~busy_vec;

  // Hazard check looks only at registered counts; same-cycle releases are not bypassed.
  assign issue_ready = reset_n
                    && (state_reg == SB_RUN)
                    && !(issue_src_a_en && busy_vec[issue_src_a])
                    && !(issue_src_b_en && busy_vec[issue_src_b])
                    && !(issue_dst_en && full_vec[issue_dst]);

  always_comb begin
    rel_sum = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      rel_sum = rel_sum + TOTAL_W'(applied_arr[r]);
    end
    total_next = total_reg + TOTAL_W'(issue_write) - rel_sum;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SB_RUN: begin
        if (drain_req) state_next = SB_DRAINING;
      end
      SB_DRAINING: begin
        if (!drain_req)            state_next = SB_RUN;
        else if (total_next == '0) state_next = SB_DRAINED;
      end
      SB_DRAINED: begin
        if (!drain_req) state_next = SB_RUN;
      end
      default: state_next = SB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= SB_RUN;
      total_reg         <= '0;
      underflow_err_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      total_reg         <= total_next;
      underflow_err_reg <= underflow_err_reg || (|uf_vec);
    end
  end

  assign outstanding_total = total_reg;
  assign underflow_err     = underflow_err_reg;
  assign drain_ack         = (state_reg == SB_DRAINED);

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: hazards, saturation, dual release,
// underflow, drain handshake and mid-operation reset.
module tb_register_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_src_a;
  logic [3:0]  issue_src_b;
  logic        issue_src_a_en;
  logic        issue_src_b_en;
  logic [3:0]  issue_dst;
  logic        issue_dst_en;
  logic [1:0]  wb_valid;
  logic [3:0]  wb_reg_exec;
  logic [3:0]  wb_reg_load;
  logic        drain_req;
  logic        drain_ack;
  logic [15:0] reg_valid;
  logic [6:0]  outstanding_total;
  logic        underflow_err;

  int tests_run;
  int tests_failed;

  register_scoreboard dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_src_a       (issue_src_a),
    .issue_src_b       (issue_src_b),
    .issue_src_a_en    (issue_src_a_en),
    .issue_src_b_en    (issue_src_b_en),
    .issue_dst         (issue_dst),
    .issue_dst_en      (issue_dst_en),
    .wb_valid          (wb_valid),
    .wb_reg            ({wb_reg_load, wb_reg_exec}),
    .drain_req         (drain_req),
    .drain_ack         (drain_ack),
    .reg_valid         (reg_valid),
    .outstanding_total (outstanding_total),
    .underflow_err     (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_src_a    = '0;
    issue_src_b    = '0;
    issue_src_a_en = 1'b0;
    issue_src_b_en = 1'b0;
    issue_dst      = '0;
    issue_dst_en   = 1'b0;
    wb_valid       = 2'b00;
    wb_reg_exec    = '0;
    wb_reg_load    = '0;
  endtask

  task automatic present_write(input logic [3:0] dst);
    issue_valid  = 1'b1;
    issue_dst    = dst;
    issue_dst_en = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    drain_req = 1'b0;
    reset_n   = 1'b0;
    tick();
    present_write(4'd1);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0", issue_ready);
    end
    tick();
    idle();
    tests_run++;
    if (reg_valid !== 16'hFFFF || outstanding_total !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_state: reg_valid=%h total=%0d expected ffff/0", reg_valid, outstanding_total);
    end
    tests_run++;
    if (drain_ack !== 1'b0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: drain_ack=%b underflow=%b expected 0/0", drain_ack, underflow_err);
    end
    reset_n = 1'b1;
    $display("[TB] reset: reg_valid=%h total=%0d", reg_valid, outstanding_total);
  endtask

  task automatic test_raw_hazard();
    present_write(4'd3);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL raw_first_ready: got %b expected 1", issue_ready);
    end
    tick();
    idle();
    tests_run++;
    if (reg_valid[3] !== 1'b0 || outstanding_total !== 7'd1) begin
      tests_failed++;
      $display("FAIL raw_busy: reg_valid[3]=%b total=%0d expected 0/1", reg_valid[3], outstanding_total);
    end
    issue_valid    = 1'b1;
    issue_src_a    = 4'd3;
    issue_src_a_en = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL raw_stall: got %b expected 0", issue_ready);
    end
    tick();
    wb_valid    = 2'b01;
    wb_reg_exec = 4'd3;
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL raw_no_bypass: got %b expected 0", issue_ready);
    end
    tick();
    wb_valid = 2'b00;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || reg_valid[3] !== 1'b1 || outstanding_total !== 7'd0) begin
      tests_failed++;
      $display("FAIL raw_release: ready=%b reg_valid[3]=%b total=%0d expected 1/1/0",
               issue_ready, reg_valid[3], outstanding_total);
    end
    tick();
    idle();
    $display("[TB] raw_hazard: total=%0d", outstanding_total);
  endtask

  task automatic test_saturate();
    present_write(4'd5);
    for (int i = 0; i < 7; i++) tick();
    #1;
    tests_run++;
    if (issue_ready !== 1'b0 || outstanding_total !== 7'd7 || reg_valid[5] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_full: ready=%b total=%0d expected 0/7", issue_ready, outstanding_total);
    end
    tick();
    tests_run++;
    if (outstanding_total !== 7'd7) begin
      tests_failed++;
      $display("FAIL sat_hold: total=%0d expected 7", outstanding_total);
    end
    issue_valid = 1'b0;
    wb_valid    = 2'b10;
    wb_reg_load = 4'd5;
    tick();
    wb_valid    = 2'b00;
    issue_valid = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || outstanding_total !== 7'd6) begin
      tests_failed++;
      $display("FAIL sat_release: ready=%b total=%0d expected 1/6", issue_ready, outstanding_total);
    end
    idle();
    wb_valid    = 2'b11;
    wb_reg_exec = 4'd5;
    wb_reg_load = 4'd5;
    for (int i = 0; i < 3; i++) tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd0 || reg_valid !== 16'hFFFF || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_drainout: total=%0d reg_valid=%h uf=%b expected 0/ffff/0",
               outstanding_total, reg_valid, underflow_err);
    end
    $display("[TB] saturate: total=%0d", outstanding_total);
  endtask

  task automatic test_cancel();
    present_write(4'd2);
    tick();
    idle();
    present_write(4'd2);
    wb_valid    = 2'b01;
    wb_reg_exec = 4'd2;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || outstanding_total !== 7'd1) begin
      tests_failed++;
      $display("FAIL cancel_pre: ready=%b total=%0d expected 1/1", issue_ready, outstanding_total);
    end
    tick();
    idle();
    tests_run++;
    if (reg_valid[2] !== 1'b0 || outstanding_total !== 7'd1 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cancel_post: reg_valid[2]=%b total=%0d uf=%b expected 0/1/0",
               reg_valid[2], outstanding_total, underflow_err);
    end
    wb_valid    = 2'b01;
    wb_reg_exec = 4'd2;
    tick();
    idle();
    tests_run++;
    if (reg_valid[2] !== 1'b1 || outstanding_total !== 7'd0) begin
      tests_failed++;
      $display("FAIL cancel_clear: reg_valid[2]=%b total=%0d expected 1/0", reg_valid[2], outstanding_total);
    end
    $display("[TB] cancel: total=%0d", outstanding_total);
  endtask

  task automatic test_dual_release();
    present_write(4'd4);
    tick();
    tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd2) begin
      tests_failed++;
      $display("FAIL dual_setup: total=%0d expected 2", outstanding_total);
    end
    wb_valid    = 2'b11;
    wb_reg_exec = 4'd4;
    wb_reg_load = 4'd4;
    tick();
    tests_run++;
    if (reg_valid[4] !== 1'b1 || outstanding_total !== 7'd0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dual_release: reg_valid[4]=%b total=%0d uf=%b expected 1/0/0",
               reg_valid[4], outstanding_total, underflow_err);
    end
    tick();
    idle();
    tests_run++;
    if (underflow_err !== 1'b1 || reg_valid[4] !== 1'b1 || outstanding_total !== 7'd0) begin
      tests_failed++;
      $display("FAIL dual_underflow: uf=%b reg_valid[4]=%b total=%0d expected 1/1/0",
               underflow_err, reg_valid[4], outstanding_total);
    end
    tick();
    tests_run++;
    if (underflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL dual_sticky: uf=%b expected 1", underflow_err);
    end
    $display("[TB] dual_release: uf=%b total=%0d", underflow_err, outstanding_total);
  endtask

  task automatic test_drain();
    present_write(4'd1);
    tick();
    issue_dst = 4'd2;
    tick();
    issue_dst = 4'd6;
    tick();
    idle();
    drain_req = 1'b1;
    tick();
    present_write(4'd7);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0 || drain_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_block: ready=%b ack=%b expected 0/0", issue_ready, drain_ack);
    end
    tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd3) begin
      tests_failed++;
      $display("FAIL drain_no_issue: total=%0d expected 3", outstanding_total);
    end
    wb_valid    = 2'b11;
    wb_reg_exec = 4'd1;
    wb_reg_load = 4'd2;
    tick();
    idle();
    tests_run++;
    if (drain_ack !== 1'b0 || outstanding_total !== 7'd1) begin
      tests_failed++;
      $display("FAIL drain_partial: ack=%b total=%0d expected 0/1", drain_ack, outstanding_total);
    end
    wb_valid    = 2'b01;
    wb_reg_exec = 4'd6;
    tick();
    idle();
    tests_run++;
    if (drain_ack !== 1'b1 || outstanding_total !== 7'd0) begin
      tests_failed++;
      $display("FAIL drain_ack: ack=%b total=%0d expected 1/0", drain_ack, outstanding_total);
    end
    tick();
    drain_req = 1'b0;
    present_write(4'd7);
    #1;
    tests_run++;
    if (drain_ack !== 1'b1 || issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_hold: ack=%b ready=%b expected 1/0", drain_ack, issue_ready);
    end
    tick();
    tests_run++;
    if (drain_ack !== 1'b0 || issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_resume: ack=%b ready=%b expected 0/1", drain_ack, issue_ready);
    end
    tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd1 || reg_valid[7] !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_issue: total=%0d reg_valid[7]=%b expected 1/0", outstanding_total, reg_valid[7]);
    end
    $display("[TB] drain: ack=%b total=%0d", drain_ack, outstanding_total);
  endtask

  task automatic test_reset_mid();
    present_write(4'd8);
    tick();
    issue_dst = 4'd9;
    tick();
    issue_dst = 4'd10;
    tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd4) begin
      tests_failed++;
      $display("FAIL mid_setup: total=%0d expected 4", outstanding_total);
    end
    reset_n     = 1'b0;
    wb_valid    = 2'b01;
    wb_reg_exec = 4'd7;
    tick();
    reset_n = 1'b1;
    idle();
    tests_run++;
    if (reg_valid !== 16'hFFFF || outstanding_total !== 7'd0 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: reg_valid=%h total=%0d uf=%b expected ffff/0/0",
               reg_valid, outstanding_total, underflow_err);
    end
    present_write(4'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || drain_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_run: ready=%b ack=%b expected 1/0", issue_ready, drain_ack);
    end
    tick();
    idle();
    tests_run++;
    if (outstanding_total !== 7'd1 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_after: total=%0d uf=%b expected 1/0", outstanding_total, underflow_err);
    end
    $display("[TB] reset_mid: total=%0d", outstanding_total);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_raw_hazard();
    test_saturate();
    test_cancel();
    test_dual_release();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
